// File: rtl/keypad_scan_entry_if.sv
// Keypad-side and entry-register signals of keypad_scan_entry.
// slave: the scanner itself; master: the board/keypad side that reads it.
interface keypad_scan_entry_if;
  logic [3:0]  Col_In;
  logic [3:0]  Row_Out;
  logic [3:0]  Key_Code;
  logic        Key_Valid;
  logic        Key_Down;
  logic [23:0] Hex_SixNum;

  modport slave (
    input  Col_In,
    output Row_Out,
    output Key_Code,
    output Key_Valid,
    output Key_Down,
    output Hex_SixNum
  );

  modport master (
    output Col_In,
    input  Row_Out,
    input  Key_Code,
    input  Key_Valid,
    input  Key_Down,
    input  Hex_SixNum
  );
endinterface

// File: rtl/keypad_scan_entry.sv
// 4x4 matrix keypad scanner: drives one row low at a time, debounces the columns and
// shifts each accepted key code into a 6-digit hex entry register.
module keypad_scan_entry #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned DEB_TICKS = 20
) (
  input  logic               i_clk,
  input  logic               i_rst,
  keypad_scan_entry_if.slave kp
);

  localparam int unsigned TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DW = $clog2(DEB_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_TICKS);

  localparam logic [1:0] S_SCAN     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_PRESSED  = 2'd2;

  logic [3:0]    r_sync1, r_sync2;
  logic [TW-1:0] r_tick_cnt;
  logic [1:0]    r_state;
  logic [1:0]    r_row, r_col;
  logic [DW-1:0] r_deb_cnt, r_rel_cnt;
  logic [3:0]    r_key_code;
  logic          r_key_valid, r_key_down;
  logic [23:0]   r_hex;

  logic          w_tick;
  logic          w_any_low;
  logic          w_sel_high;
  logic [1:0]    w_sel_col;
  logic [1:0]    w_state_d;
  logic [1:0]    w_row_d, w_col_d;
  logic [DW-1:0] w_deb_d, w_rel_d;
  logic          w_down_d;
  logic          w_emit;
  logic [3:0]    w_code;

  assign w_tick     = (r_tick_cnt == TICK_LAST);
  assign w_any_low  = (r_sync2 != 4'hF);
  assign w_sel_high = r_sync2[r_col];
  assign w_code     = {r_row, w_col_d};

  // Lowest-index low column wins when several are pressed on the same row
  always_comb begin
    w_sel_col = 2'd3;
    if (!r_sync2[0])      w_sel_col = 2'd0;
    else if (!r_sync2[1]) w_sel_col = 2'd1;
    else if (!r_sync2[2]) w_sel_col = 2'd2;
  end

  always_comb begin
    w_state_d = r_state;
    w_row_d   = r_row;
    w_col_d   = r_col;
    w_deb_d   = r_deb_cnt;
    w_rel_d   = r_rel_cnt;
    w_down_d  = r_key_down;
    w_emit    = 1'b0;
    if (w_tick) begin
      case (r_state)
        S_SCAN: begin
          if (w_any_low) begin
            w_col_d = w_sel_col;
            w_deb_d = DW'(1);
            if (DEB_TICKS <= 1) w_emit = 1'b1;
            else                w_state_d = S_DEBOUNCE;
          end else begin
            w_row_d = r_row + 2'd1;
          end
        end
        S_DEBOUNCE: begin
          if (w_sel_high) begin
            w_state_d = S_SCAN;
            w_row_d   = r_row + 2'd1;
          end else if (r_deb_cnt + DW'(1) >= DEB_LAST) begin
            w_deb_d = DEB_LAST;
            w_emit  = 1'b1;
          end else begin
            w_deb_d = r_deb_cnt + DW'(1);
          end
        end
        S_PRESSED: begin
          if (!w_sel_high) begin
            w_rel_d = '0;
          end else if (r_rel_cnt + DW'(1) >= DEB_LAST) begin
            w_rel_d   = '0;
            w_down_d  = 1'b0;
            w_state_d = S_SCAN;
            w_row_d   = r_row + 2'd1;
          end else begin
            w_rel_d = r_rel_cnt + DW'(1);
          end
        end
        default: w_state_d = S_SCAN;
      endcase
    end
    if (w_emit) begin
      w_state_d = S_PRESSED;
      w_rel_d   = '0;
      w_down_d  = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1     <= 4'hF;
      r_sync2     <= 4'hF;
      r_tick_cnt  <= '0;
      r_state     <= S_SCAN;
      r_row       <= 2'd0;
      r_col       <= 2'd0;
      r_deb_cnt   <= '0;
      r_rel_cnt   <= '0;
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
      r_key_down  <= 1'b0;
      r_hex       <= 24'h0;
    end else begin
      r_sync1     <= kp.Col_In;
      r_sync2     <= r_sync1;
      r_tick_cnt  <= w_tick ? '0 : r_tick_cnt + TW'(1);
      r_state     <= w_state_d;
      r_row       <= w_row_d;
      r_col       <= w_col_d;
      r_deb_cnt   <= w_deb_d;
      r_rel_cnt   <= w_rel_d;
      r_key_down  <= w_down_d;
      r_key_valid <= w_emit;
      if (w_emit) begin
        r_key_code <= w_code;
        r_hex      <= {r_hex[19:0], w_code};
      end
    end
  end

  assign kp.Row_Out    = ~(4'b0001 << r_row);
  assign kp.Key_Code   = r_key_code;
  assign kp.Key_Valid  = r_key_valid;
  assign kp.Key_Down   = r_key_down;
  assign kp.Hex_SixNum = r_hex;

endmodule

// File: tb/tb_keypad_scan_entry.sv
// Directed bench for keypad_scan_entry with a behavioural 4x4 keypad on the row/column lines.
module tb_keypad_scan_entry;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   vcnt  = 0;
  int   wide  = 0;
  int   base;
  logic prev_valid = 1'b0;
  logic [3:0] k_row [4];

  keypad_scan_entry_if kif ();

  keypad_scan_entry #(.SCAN_DIV(4), .DEB_TICKS(3)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .kp    (kif)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its column to its row; only the low row pulls columns low
  assign kif.Col_In = ~(({4{~kif.Row_Out[0]}} & k_row[0]) | ({4{~kif.Row_Out[1]}} & k_row[1]) |
                        ({4{~kif.Row_Out[2]}} & k_row[2]) | ({4{~kif.Row_Out[3]}} & k_row[3]));

  always @(negedge clk) begin
    if (kif.Key_Valid === 1'b1) begin
      vcnt <= vcnt + 1;
      if (prev_valid) wide <= wide + 1;
    end
    prev_valid <= kif.Key_Valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (kif.Key_Valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, " valid seen"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_released(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (kif.Key_Down === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, " released"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_row_start(input logic [3:0] target);
    logic [3:0] prev = kif.Row_Out;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (prev !== target && kif.Row_Out === target) break;
      prev = kif.Row_Out;
    end
    check("row start", 32'(kif.Row_Out), 32'(target));
  endtask

  task automatic press_key(input int r, input logic [3:0] mask, input logic [3:0] code,
                           input string tag);
    k_row[r] = mask;
    wait_valid(tag);
    check({tag, " code"}, 32'(kif.Key_Code), 32'(code));
    k_row[r] = 4'h0;
    wait_released(tag);
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_rows [4];
    exp_rows[0] = 4'b1110; exp_rows[1] = 4'b1101; exp_rows[2] = 4'b1011; exp_rows[3] = 4'b0111;
    for (int i = 0; i < 4; i++) k_row[i] = 4'h0;

    // Power-up reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst row", 32'(kif.Row_Out), 32'h E);
    check("rst valid", 32'(kif.Key_Valid), 32'd0);
    check("rst down", 32'(kif.Key_Down), 32'd0);
    check("rst code", 32'(kif.Key_Code), 32'd0);
    check("rst hex", 32'(kif.Hex_SixNum), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Long hold of row1/col2: one pulse, code 6
    repeat (8) @(negedge clk);
    base = vcnt;
    k_row[1] = 4'b0100;
    wait_valid("hold");
    check("hold code", 32'(kif.Key_Code), 32'h6);
    check("hold hex", 32'(kif.Hex_SixNum), 32'h000006);
    check("hold down", 32'(kif.Key_Down), 32'd1);
    repeat (80) @(negedge clk);
    check("hold one pulse", 32'(vcnt), 32'(base + 1));
    check("hold down held", 32'(kif.Key_Down), 32'd1);
    k_row[1] = 4'h0;
    wait_released("hold");

    // Bounce on row2/col0 seen for 2 ticks only
    base = vcnt;
    wait_row_start(4'b1011);
    k_row[2] = 4'b0001;
    repeat (8) @(posedge clk);
    #1;
    k_row[2] = 4'h0;
    repeat (4) @(posedge clk);
    #1;
    check("bounce row advance", 32'(kif.Row_Out), 32'h7);
    check("bounce down", 32'(kif.Key_Down), 32'd0);
    for (int i = 0; i < 4; i++) begin
      repeat (4) @(posedge clk);
      #1;
      check("bounce rotate", 32'(kif.Row_Out), 32'(exp_rows[i]));
    end
    check("bounce no pulse", 32'(vcnt), 32'(base));

    // Codes 1..7 into the entry register
    base = vcnt;
    press_key(0, 4'b0010, 4'h1, "k1");
    press_key(0, 4'b0100, 4'h2, "k2");
    press_key(0, 4'b1000, 4'h3, "k3");
    press_key(1, 4'b0001, 4'h4, "k4");
    press_key(1, 4'b0010, 4'h5, "k5");
    press_key(1, 4'b0100, 4'h6, "k6");
    press_key(1, 4'b1000, 4'h7, "k7");
    check("seq hex", 32'(kif.Hex_SixNum), 32'h234567);
    check("seq pulses", 32'(vcnt), 32'(base + 7));

    // Two columns low on row3: col0 wins
    press_key(3, 4'b1001, 4'hC, "multi");
    check("multi hex", 32'(kif.Hex_SixNum), 32'h34567C);

    // Release glitch of 2 ticks while pressed, then a second key on the same row
    base = vcnt;
    k_row[2] = 4'b0010;
    wait_valid("glitch");
    check("glitch code", 32'(kif.Key_Code), 32'h9);
    k_row[2] = 4'h0;
    repeat (8) @(posedge clk);
    #1;
    k_row[2] = 4'b0010;
    repeat (20) @(negedge clk);
    check("glitch down", 32'(kif.Key_Down), 32'd1);
    k_row[2] = 4'b1010;
    repeat (20) @(negedge clk);
    check("glitch no pulse", 32'(vcnt), 32'(base + 1));
    check("glitch row held", 32'(kif.Row_Out), 32'hB);
    check("glitch down2", 32'(kif.Key_Down), 32'd1);

    // Asynchronous reset while pressed, key still held through it
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid rst row", 32'(kif.Row_Out), 32'hE);
    check("mid rst valid", 32'(kif.Key_Valid), 32'd0);
    check("mid rst down", 32'(kif.Key_Down), 32'd0);
    check("mid rst code", 32'(kif.Key_Code), 32'd0);
    check("mid rst hex", 32'(kif.Hex_SixNum), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    base = vcnt;
    wait_valid("redetect");
    check("redetect code", 32'(kif.Key_Code), 32'h9);
    check("redetect hex", 32'(kif.Hex_SixNum), 32'h000009);
    repeat (40) @(negedge clk);
    check("redetect one pulse", 32'(vcnt), 32'(base + 1));
    check("redetect down", 32'(kif.Key_Down), 32'd1);
    k_row[2] = 4'h0;
    wait_released("redetect");
    check("pulse width", 32'(wide), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
